tcp_session_fsm: RTL and testbench

Client-side TCP connection state machine sitting directly downstream of the TCP flag checker in the router output-port-lookup path. It pops the checker's parsed-segment FIFO and tracks one connection: SYN, SYN-ACK/ACK handshake, established acknowledgement tracking and FIN teardown. It issues transmit-request descriptors (type, seq, ack, TSval, TSecr) to the packet generator over a valid/ready handshake. It also owns SYN/FIN retransmission timing and the local TCP timestamp clock.

---
 rtl/tcp_sess_pkg.sv | 30 +++
 rtl/tcp_session_fsm_ts_clock.sv | 46 ++++
 rtl/tcp_session_fsm.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_tcp_session_fsm.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_sess_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_sess_pkg
//  Description : Shared state codes, descriptor type codes and field widths
//                for the client-side TCP session tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package tcp_sess_pkg;

   localparam int SEQ_W  = 32;
   localparam int TS_W   = 32;
   localparam int DROP_W = 16;

   typedef enum logic [2:0] {
      ST_CLOSED   = 3'd0,
      ST_SYN_SENT = 3'd1,
      ST_ESTAB    = 3'd2,
      ST_FIN_WAIT = 3'd3,
      ST_LAST_ACK = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      TX_SYN  = 2'd0,
      TX_ACK  = 2'd1,
      TX_FIN  = 2'd2,
      TX_RSVD = 2'd3
   } tx_type_e;

endpackage
`default_nettype wire

// File: rtl/tcp_session_fsm_ts_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_ts_clock
//  Description : Local TCP timestamp clock. A TS_DIV prescaler advances a
//                free-running 32-bit TSval counter once per TS_DIV cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_ts_clock
   import tcp_sess_pkg::*;
#(
   parameter int TS_DIV = 200_000
) (
   input  logic            clk,
   input  logic            resetn,
   output logic [TS_W-1:0] tsval
);

   localparam int                c_pre_w    = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TS_DIV - 1);

   logic [c_pre_w-1:0] pre_q, pre_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic               tick;

   // Prescaler wraps after TS_DIV cycles and advances TSval on the wrap
   always_comb begin
      tick  = (pre_q == c_pre_last);
      pre_d = tick ? '0 : pre_q + c_pre_w'(1);
      ts_d  = tick ? ts_q + TS_W'(1) : ts_q;
   end

   // Prescaler and TSval registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre_q <= '0;
         ts_q  <= '0;
      end else begin
         pre_q <= pre_d;
         ts_q  <= ts_d;
      end
   end

   assign tsval = ts_q;

endmodule
`default_nettype wire

// File: rtl/tcp_session_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_session_fsm
//  Description : Client-side TCP connection tracker. Pops the flag checker's
//                segment FIFO, runs handshake / established / teardown,
//                issues transmit descriptors and owns SYN/FIN retransmission.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_session_fsm
   import tcp_sess_pkg::*;
#(
   parameter logic [31:0] RTO_CYCLES = 32'd200_000_000,
   parameter int          MAX_RETRY  = 3,
   parameter int          TS_DIV     = 200_000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              conn_open,
   input  logic              conn_close,
   input  logic [SEQ_W-1:0]  isn,
   input  logic              hand_shake_vld,
   input  logic              is_tcp_hand_shake,
   input  logic              is_tcp_ack,
   input  logic              is_tcp_fin,
   input  logic [SEQ_W-1:0]  seq_value,
   input  logic [SEQ_W-1:0]  ack_value,
   input  logic [TS_W-1:0]   ts_val,
   input  logic [TS_W-1:0]   ecr_val,
   output logic              rd_check,
   output logic              tx_vld,
   input  logic              tx_rdy,
   output logic [1:0]        tx_type,
   output logic [SEQ_W-1:0]  tx_seq,
   output logic [SEQ_W-1:0]  tx_ack,
   output logic [TS_W-1:0]   tx_tsval,
   output logic [TS_W-1:0]   tx_tsecr,
   output logic [2:0]        conn_state,
   output logic              conn_up,
   output logic              conn_fail,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int c_retry_w = $clog2(MAX_RETRY + 1);
   localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRY);
   // Emit cycle plus the one-cycle descriptor handshake are not counted by
   // the timer, so it is loaded two short to keep emit-to-emit at RTO_CYCLES.
   localparam logic [31:0] c_rto_load = RTO_CYCLES - 32'd2;

   state_e              state_q, state_d;
   logic [SEQ_W-1:0]    snd_nxt_q, snd_nxt_d;
   logic [SEQ_W-1:0]    rcv_nxt_q, rcv_nxt_d;
   logic [TS_W-1:0]     peer_ts_q, peer_ts_d;
   logic [31:0]         rto_q, rto_d;
   logic [c_retry_w-1:0] retry_q, retry_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic                tx_vld_q, tx_vld_d;
   tx_type_e            tx_type_q, tx_type_d;
   logic [SEQ_W-1:0]    tx_seq_q, tx_seq_d;
   logic [SEQ_W-1:0]    tx_ack_q, tx_ack_d;
   logic [TS_W-1:0]     tx_tsval_q, tx_tsval_d;
   logic [TS_W-1:0]     tx_tsecr_q, tx_tsecr_d;
   logic                conn_up_q, conn_up_d;
   logic                conn_fail_q, conn_fail_d;

   logic [TS_W-1:0]     ts_now;
   logic                timer_run, timer_exp;
   logic                emit, do_drop, load_timer;
   tx_type_e            emit_type;
   logic [SEQ_W-1:0]    emit_seq;
   // Peer TSecr is carried by the checker but not needed (no RTT estimation)
   logic                unused_ecr;

   assign unused_ecr = ^ecr_val;

   tcp_ts_clock #(
      .TS_DIV (TS_DIV)
   ) u_ts_clock (
      .clk    (clk),
      .resetn (resetn),
      .tsval  (ts_now)
   );

   // The FIFO is fall-through: popping is only blocked by a pending descriptor
   assign rd_check  = hand_shake_vld & ~tx_vld_q;
   assign timer_run = (state_q == ST_SYN_SENT) | (state_q == ST_FIN_WAIT) |
                      (state_q == ST_LAST_ACK);
   assign timer_exp = timer_run & ~tx_vld_q & (rto_q == '0);

   // Next-state, register updates and descriptor composition
   always_comb begin
      state_d     = state_q;
      snd_nxt_d   = snd_nxt_q;
      rcv_nxt_d   = rcv_nxt_q;
      peer_ts_d   = peer_ts_q;
      rto_d       = rto_q;
      retry_d     = retry_q;
      drop_cnt_d  = drop_cnt_q;
      tx_vld_d    = tx_vld_q;
      tx_type_d   = tx_type_q;
      tx_seq_d    = tx_seq_q;
      tx_ack_d    = tx_ack_q;
      tx_tsval_d  = tx_tsval_q;
      tx_tsecr_d  = tx_tsecr_q;
      conn_fail_d = 1'b0;
      emit        = 1'b0;
      emit_type   = TX_ACK;
      emit_seq    = snd_nxt_q;
      do_drop     = 1'b0;
      load_timer  = 1'b0;

      if (tx_vld_q && tx_rdy) begin
         tx_vld_d = 1'b0;
      end
      if (!tx_vld_q && (rto_q != '0)) begin
         rto_d = rto_q - 32'd1;
      end

      if (rd_check) begin
         // Any pop in a timed state restarts the timer, so pop beats expiry
         load_timer = timer_run;
         case (state_q)
            ST_SYN_SENT: begin
               if (!is_tcp_fin && is_tcp_hand_shake && (ack_value == snd_nxt_q)) begin
                  rcv_nxt_d = seq_value;
                  peer_ts_d = ts_val;
                  emit      = 1'b1;
                  emit_type = TX_ACK;
                  retry_d   = '0;
                  state_d   = ST_ESTAB;
               end else begin
                  do_drop = 1'b1;
               end
            end
            ST_ESTAB: begin
               if (is_tcp_fin) begin
                  // Our FIN consumes one sequence number, as on the close path
                  rcv_nxt_d  = seq_value;
                  emit       = 1'b1;
                  emit_type  = TX_FIN;
                  snd_nxt_d  = snd_nxt_q + SEQ_W'(1);
                  load_timer = 1'b1;
                  retry_d    = '0;
                  state_d    = ST_LAST_ACK;
               end else if (!is_tcp_hand_shake && is_tcp_ack) begin
                  rcv_nxt_d = seq_value;
                  snd_nxt_d = ack_value;
                  peer_ts_d = ts_val;
               end else begin
                  do_drop = 1'b1;
               end
            end
            ST_FIN_WAIT: begin
               if (is_tcp_fin) begin
                  rcv_nxt_d = seq_value;
                  emit      = 1'b1;
                  emit_type = TX_ACK;
                  state_d   = ST_CLOSED;
               end else if (!is_tcp_hand_shake && is_tcp_ack) begin
                  // snd_nxt is frozen so a FIN retransmit keeps its sequence
                  rcv_nxt_d = seq_value;
                  peer_ts_d = ts_val;
               end else begin
                  do_drop = 1'b1;
               end
            end
            ST_LAST_ACK: begin
               if (!is_tcp_fin && !is_tcp_hand_shake && is_tcp_ack) begin
                  state_d = ST_CLOSED;
               end else begin
                  do_drop = 1'b1;
               end
            end
            default: begin
               do_drop = 1'b1;
            end
         endcase
      end else if (timer_exp) begin
         if (retry_q == c_retry_max) begin
            conn_fail_d = 1'b1;
            retry_d     = '0;
            state_d     = ST_CLOSED;
         end else begin
            retry_d    = retry_q + c_retry_w'(1);
            emit       = 1'b1;
            emit_seq   = snd_nxt_q - SEQ_W'(1);
            load_timer = 1'b1;
            if (state_q == ST_SYN_SENT) begin
               emit_type = TX_SYN;
            end else begin
               emit_type = TX_FIN;
            end
         end
      end else if (!tx_vld_q && (state_q == ST_ESTAB) && conn_close) begin
         emit       = 1'b1;
         emit_type  = TX_FIN;
         snd_nxt_d  = snd_nxt_q + SEQ_W'(1);
         load_timer = 1'b1;
         retry_d    = '0;
         state_d    = ST_FIN_WAIT;
      end

      // Opening is independent of a same-cycle pop, which is simply dropped
      if (!tx_vld_q && (state_q == ST_CLOSED) && conn_open) begin
         snd_nxt_d  = isn + SEQ_W'(1);
         rcv_nxt_d  = '0;
         peer_ts_d  = '0;
         emit       = 1'b1;
         emit_type  = TX_SYN;
         emit_seq   = isn;
         load_timer = 1'b1;
         retry_d    = '0;
         state_d    = ST_SYN_SENT;
      end

      if (do_drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
      if (load_timer) begin
         rto_d = c_rto_load;
      end
      // Descriptor fields are sampled from the post-update connection state
      if (emit) begin
         tx_vld_d   = 1'b1;
         tx_type_d  = emit_type;
         tx_seq_d   = emit_seq;
         tx_ack_d   = rcv_nxt_d;
         tx_tsval_d = ts_now;
         tx_tsecr_d = peer_ts_d;
      end
      conn_up_d = (state_d == ST_ESTAB);
   end

   // Connection state, counters and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_CLOSED;
         snd_nxt_q   <= '0;
         rcv_nxt_q   <= '0;
         peer_ts_q   <= '0;
         rto_q       <= '0;
         retry_q     <= '0;
         drop_cnt_q  <= '0;
         tx_vld_q    <= 1'b0;
         tx_type_q   <= TX_SYN;
         tx_seq_q    <= '0;
         tx_ack_q    <= '0;
         tx_tsval_q  <= '0;
         tx_tsecr_q  <= '0;
         conn_up_q   <= 1'b0;
         conn_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         snd_nxt_q   <= snd_nxt_d;
         rcv_nxt_q   <= rcv_nxt_d;
         peer_ts_q   <= peer_ts_d;
         rto_q       <= rto_d;
         retry_q     <= retry_d;
         drop_cnt_q  <= drop_cnt_d;
         tx_vld_q    <= tx_vld_d;
         tx_type_q   <= tx_type_d;
         tx_seq_q    <= tx_seq_d;
         tx_ack_q    <= tx_ack_d;
         tx_tsval_q  <= tx_tsval_d;
         tx_tsecr_q  <= tx_tsecr_d;
         conn_up_q   <= conn_up_d;
         conn_fail_q <= conn_fail_d;
      end
   end

   assign tx_vld     = tx_vld_q;
   assign tx_type    = tx_type_q;
   assign tx_seq     = tx_seq_q;
   assign tx_ack     = tx_ack_q;
   assign tx_tsval   = tx_tsval_q;
   assign tx_tsecr   = tx_tsecr_q;
   assign conn_state = state_q;
   assign conn_up    = conn_up_q;
   assign conn_fail  = conn_fail_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tcp_session_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tcp_session_fsm
//  Description : Self-checking bench for tcp_session_fsm with randomized
//                segment values and a connection-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_session_fsm;

   localparam logic [31:0] RTO     = 32'd100;
   localparam int          RETRIES = 3;
   localparam int          TSD     = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        conn_open = 1'b0, conn_close = 1'b0;
   logic [31:0] isn = '0;
   logic        hand_shake_vld = 1'b0;
   logic        is_tcp_hand_shake = 1'b0, is_tcp_ack = 1'b0, is_tcp_fin = 1'b0;
   logic [31:0] seq_value = '0, ack_value = '0, ts_val = '0, ecr_val = '0;
   logic        rd_check, tx_vld;
   logic        tx_rdy = 1'b1;
   logic [1:0]  tx_type;
   logic [31:0] tx_seq, tx_ack, tx_tsval, tx_tsecr;
   logic [2:0]  conn_state;
   logic        conn_up, conn_fail;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad   = 0;
   int edge_cnt;

   always #5 clk = ~clk;

   // Edges seen since reset release: the local TS clock is edge_cnt / TSD
   always @(posedge clk or negedge resetn) begin
      if (!resetn) edge_cnt <= 0;
      else         edge_cnt <= edge_cnt + 1;
   end

   tcp_session_fsm #(
      .RTO_CYCLES (RTO),
      .MAX_RETRY  (RETRIES),
      .TS_DIV     (TSD)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .conn_open         (conn_open),
      .conn_close        (conn_close),
      .isn               (isn),
      .hand_shake_vld    (hand_shake_vld),
      .is_tcp_hand_shake (is_tcp_hand_shake),
      .is_tcp_ack        (is_tcp_ack),
      .is_tcp_fin        (is_tcp_fin),
      .seq_value         (seq_value),
      .ack_value         (ack_value),
      .ts_val            (ts_val),
      .ecr_val           (ecr_val),
      .rd_check          (rd_check),
      .tx_vld            (tx_vld),
      .tx_rdy            (tx_rdy),
      .tx_type           (tx_type),
      .tx_seq            (tx_seq),
      .tx_ack            (tx_ack),
      .tx_tsval          (tx_tsval),
      .tx_tsecr          (tx_tsecr),
      .conn_state        (conn_state),
      .conn_up           (conn_up),
      .conn_fail         (conn_fail),
      .drop_cnt          (drop_cnt)
   );

   task automatic clear_inputs();
      conn_open = 1'b0; conn_close = 1'b0; isn = '0;
      hand_shake_vld = 1'b0; is_tcp_hand_shake = 1'b0; is_tcp_ack = 1'b0; is_tcp_fin = 1'b0;
      seq_value = '0; ack_value = '0; ts_val = '0; ecr_val = '0; tx_rdy = 1'b1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clear_inputs();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
   endtask

   // One FIFO entry presented for exactly one cycle
   task automatic push(input bit f, input bit h, input bit a,
                       input logic [31:0] s, input logic [31:0] ak, input logic [31:0] t);
      hand_shake_vld = 1'b1; is_tcp_fin = f; is_tcp_hand_shake = h; is_tcp_ack = a;
      seq_value = s; ack_value = ak; ts_val = t; ecr_val = $urandom;
      @(negedge clk);
      hand_shake_vld = 1'b0; is_tcp_fin = 1'b0; is_tcp_hand_shake = 1'b0; is_tcp_ack = 1'b0;
   endtask

   task automatic wait_tx(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_vld === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic open_conn(input logic [31:0] isn_v, input logic [31:0] pseq,
                            input logic [31:0] pts, output bit ok);
      bit got;
      ok = 1'b1;
      conn_open = 1'b1; isn = isn_v;
      @(negedge clk);
      conn_open = 1'b0;
      wait_tx(4, got);
      if (!got) ok = 1'b0;
      @(negedge clk);
      push(1'b0, 1'b1, 1'b0, pseq, isn_v + 32'd1, pts);
      wait_tx(4, got);
      if (!got) ok = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [181:0] outs;
      resetn = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      outs = {rd_check, tx_vld, tx_type, tx_seq, tx_ack, tx_tsval, tx_tsecr,
              conn_state, conn_up, conn_fail, drop_cnt};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want all zero", outs);
      end
      resetn = 1'b1;
      @(negedge clk);
      total++;
      if (tx_vld !== 1'b0 || conn_state !== 3'd0 || drop_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_idle: got vld=%b state=%0d drop=%0d want 0 0 0", tx_vld, conn_state, drop_cnt);
      end
   endtask

   task automatic test_open();
      bit got;
      int exp_ts;
      logic [31:0] pts;
      do_reset();
      repeat (5) @(negedge clk);
      conn_open = 1'b1; isn = 32'h1000;
      @(negedge clk);
      conn_open = 1'b0;
      wait_tx(4, got);
      exp_ts = (edge_cnt - 1) / TSD;
      total++;
      if (!got || tx_type !== 2'd0 || tx_seq !== 32'h1000 || tx_ack !== 32'h0 ||
          tx_tsecr !== 32'h0 || tx_tsval !== 32'(exp_ts) || conn_state !== 3'd1) begin
         bad++;
         $display("FAIL open_syn: got vld=%b type=%0d seq=%h ack=%h tsval=%0d tsecr=%h state=%0d want type=0 seq=00001000 ack=0 tsval=%0d tsecr=0 state=1",
                  got, tx_type, tx_seq, tx_ack, tx_tsval, tx_tsecr, conn_state, exp_ts);
      end
      @(negedge clk);
      total++;
      if (tx_vld !== 1'b0) begin
         bad++;
         $display("FAIL open_accept: got vld=%b want 0", tx_vld);
      end
      push(1'b0, 1'b1, 1'b0, 32'h5001, 32'h2000, 32'h77);
      total++;
      if (tx_vld !== 1'b0 || drop_cnt !== 16'd1 || conn_state !== 3'd1) begin
         bad++;
         $display("FAIL synack_mismatch: got vld=%b drop=%0d state=%0d want 0 1 1", tx_vld, drop_cnt, conn_state);
      end
      pts = $urandom;
      push(1'b0, 1'b1, 1'b0, 32'h5001, 32'h1001, pts);
      exp_ts = (edge_cnt - 1) / TSD;
      total++;
      if (tx_vld !== 1'b1 || tx_type !== 2'd1 || tx_seq !== 32'h1001 || tx_ack !== 32'h5001 ||
          tx_tsecr !== pts || tx_tsval !== 32'(exp_ts)) begin
         bad++;
         $display("FAIL open_ack: got vld=%b type=%0d seq=%h ack=%h tsval=%0d tsecr=%h want 1 1 00001001 00005001 %0d %h",
                  tx_vld, tx_type, tx_seq, tx_ack, tx_tsval, tx_tsecr, exp_ts, pts);
      end
      total++;
      if (conn_up !== 1'b1 || conn_state !== 3'd2) begin
         bad++;
         $display("FAIL open_estab: got up=%b state=%0d want 1 2", conn_up, conn_state);
      end
      @(negedge clk);
   endtask

   task automatic test_peer_fin();
      bit ok;
      logic [31:0] isn_v, pts;
      do_reset();
      isn_v = $urandom; pts = $urandom;
      open_conn(isn_v, 32'h5001, pts, ok);
      total++;
      if (!ok || conn_state !== 3'd2) begin
         bad++;
         $display("FAIL fin_setup: got ok=%b state=%0d want 1 2", ok, conn_state);
      end
      push(1'b1, 1'b0, 1'b1, 32'h6001, isn_v + 32'd1, $urandom);
      total++;
      if (tx_vld !== 1'b1 || tx_type !== 2'd2 || tx_seq !== isn_v + 32'd1 || tx_ack !== 32'h6001 ||
          tx_tsecr !== pts || conn_state !== 3'd4 || conn_up !== 1'b0) begin
         bad++;
         $display("FAIL peer_fin: got vld=%b type=%0d seq=%h ack=%h tsecr=%h state=%0d up=%b want 1 2 %h 00006001 %h 4 0",
                  tx_vld, tx_type, tx_seq, tx_ack, tx_tsecr, conn_state, conn_up, isn_v + 32'd1, pts);
      end
      @(negedge clk);
      push(1'b0, 1'b0, 1'b1, 32'h6002, isn_v + 32'd2, $urandom);
      total++;
      if (tx_vld !== 1'b0 || conn_state !== 3'd0) begin
         bad++;
         $display("FAIL last_ack_close: got vld=%b state=%0d want 0 0", tx_vld, conn_state);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] isn_v, pseq, pts, s1, t1, s2;
      do_reset();
      isn_v = $urandom; pseq = $urandom; pts = $urandom;
      open_conn(isn_v, pseq, pts, ok);
      tx_rdy = 1'b0;
      conn_close = 1'b1;
      @(negedge clk);
      conn_close = 1'b0;
      s1 = $urandom; t1 = $urandom;
      hand_shake_vld = 1'b1; is_tcp_ack = 1'b1;
      seq_value = s1; ack_value = isn_v + 32'd2; ts_val = t1;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if (!ok || rd_check !== 1'b0 || tx_vld !== 1'b1 || tx_type !== 2'd2 ||
             tx_seq !== isn_v + 32'd1 || tx_ack !== pseq || tx_tsecr !== pts) begin
            bad++;
            $display("FAIL hold_fin[%0d]: got rd=%b vld=%b type=%0d seq=%h ack=%h tsecr=%h want 0 1 2 %h %h %h",
                     i, rd_check, tx_vld, tx_type, tx_seq, tx_ack, tx_tsecr, isn_v + 32'd1, pseq, pts);
         end
         @(negedge clk);
      end
      tx_rdy = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (tx_vld !== 1'b0 || rd_check !== 1'b1) begin
         bad++;
         $display("FAIL release_pop: got vld=%b rd=%b want 0 1", tx_vld, rd_check);
      end
      @(negedge clk);
      hand_shake_vld = 1'b0; is_tcp_ack = 1'b0;
      total++;
      if (tx_vld !== 1'b0 || conn_state !== 3'd3) begin
         bad++;
         $display("FAIL fin_wait_ack: got vld=%b state=%0d want 0 3", tx_vld, conn_state);
      end
      s2 = $urandom;
      push(1'b1, 1'b0, 1'b0, s2, isn_v + 32'd2, $urandom);
      total++;
      if (tx_vld !== 1'b1 || tx_type !== 2'd1 || tx_seq !== isn_v + 32'd2 || tx_ack !== s2 ||
          tx_tsecr !== t1 || conn_state !== 3'd0) begin
         bad++;
         $display("FAIL fin_wait_final: got vld=%b type=%0d seq=%h ack=%h tsecr=%h state=%0d want 1 1 %h %h %h 0",
                  tx_vld, tx_type, tx_seq, tx_ack, tx_tsecr, conn_state, isn_v + 32'd2, s2, t1);
      end
      @(negedge clk);
   endtask

   task automatic test_retry_fail();
      int syn_t[$];
      int fail_t[$];
      logic [31:0] isn_v;
      int seq_bad;
      do_reset();
      isn_v = $urandom;
      seq_bad = 0;
      conn_open = 1'b1; isn = isn_v;
      @(negedge clk);
      conn_open = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (tx_vld === 1'b1) begin
            syn_t.push_back(i);
            if (tx_type !== 2'd0 || tx_seq !== isn_v) seq_bad++;
         end
         if (conn_fail === 1'b1) fail_t.push_back(i);
         @(negedge clk);
      end
      total++;
      if (syn_t.size() != RETRIES + 1 || seq_bad != 0) begin
         bad++;
         $display("FAIL syn_count: got %0d SYNs (%0d bad fields) want %0d", syn_t.size(), seq_bad, RETRIES + 1);
      end else begin
         for (int k = 0; k <= RETRIES; k++) begin
            total++;
            if (syn_t[k] != k * int'(RTO)) begin
               bad++;
               $display("FAIL syn_time[%0d]: got %0d want %0d", k, syn_t[k], k * int'(RTO));
            end
         end
      end
      total++;
      if (fail_t.size() != 1 || (fail_t.size() == 1 && fail_t[0] != (RETRIES + 1) * int'(RTO))) begin
         bad++;
         $display("FAIL conn_fail_time: got %0d pulses first at %0d want 1 at %0d",
                  fail_t.size(), (fail_t.size() > 0) ? fail_t[0] : -1, (RETRIES + 1) * int'(RTO));
      end
      total++;
      if (conn_state !== 3'd0 || conn_up !== 1'b0) begin
         bad++;
         $display("FAIL retry_closed: got state=%0d up=%b want 0 0", conn_state, conn_up);
      end
   endtask

   task automatic test_random_estab();
      bit ok;
      int kind, drops, rises;
      logic [31:0] m_snd, m_rcv, m_pts, isn_v, s, a, t, s2;
      do_reset();
      isn_v = $urandom; m_rcv = $urandom; m_pts = $urandom;
      m_snd = isn_v + 32'd1;
      drops = 0; rises = 0;
      open_conn(isn_v, m_rcv, m_pts, ok);
      conn_open = 1'b1; isn = $urandom;
      @(negedge clk);
      conn_open = 1'b0;
      total++;
      if (!ok || tx_vld !== 1'b0 || conn_state !== 3'd2) begin
         bad++;
         $display("FAIL open_ignored: got ok=%b vld=%b state=%0d want 1 0 2", ok, tx_vld, conn_state);
      end
      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 4);
         s = $urandom; a = $urandom; t = $urandom;
         case (kind)
            1:       begin push(1'b0, 1'b1, 1'b0, s, a, t); drops++; end
            2:       begin push(1'b0, 1'b0, 1'b0, s, a, t); drops++; end
            3:       begin push(1'b0, 1'b1, 1'b1, s, a, t); drops++; end
            default: begin push(1'b0, 1'b0, 1'b1, s, a, t); m_rcv = s; m_snd = a; m_pts = t; end
         endcase
         if (tx_vld === 1'b1) rises++;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      total++;
      if (rises != 0 || drop_cnt !== 16'(drops) || conn_state !== 3'd2) begin
         bad++;
         $display("FAIL rand_estab: got tx=%0d drop=%0d state=%0d want 0 %0d 2", rises, drop_cnt, conn_state, drops);
      end
      conn_close = 1'b1;
      @(negedge clk);
      conn_close = 1'b0;
      total++;
      if (tx_vld !== 1'b1 || tx_type !== 2'd2 || tx_seq !== m_snd || tx_ack !== m_rcv || tx_tsecr !== m_pts) begin
         bad++;
         $display("FAIL rand_close_fin: got vld=%b type=%0d seq=%h ack=%h tsecr=%h want 1 2 %h %h %h",
                  tx_vld, tx_type, tx_seq, tx_ack, tx_tsecr, m_snd, m_rcv, m_pts);
      end
      @(negedge clk);
      s2 = $urandom;
      push(1'b1, 1'b1, 1'b1, s2, m_snd + 32'd1, $urandom);
      total++;
      if (tx_vld !== 1'b1 || tx_type !== 2'd1 || tx_seq !== m_snd + 32'd1 || tx_ack !== s2 ||
          tx_tsecr !== m_pts || conn_state !== 3'd0) begin
         bad++;
         $display("FAIL rand_final_ack: got vld=%b type=%0d seq=%h ack=%h tsecr=%h state=%0d want 1 1 %h %h %h 0",
                  tx_vld, tx_type, tx_seq, tx_ack, tx_tsecr, conn_state, m_snd + 32'd1, s2, m_pts);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [181:0] outs;
      do_reset();
      repeat (9) @(negedge clk);
      push(1'b0, 1'b0, 1'b1, $urandom, $urandom, $urandom);
      tx_rdy = 1'b0;
      conn_open = 1'b1; isn = $urandom;
      @(negedge clk);
      conn_open = 1'b0;
      @(negedge clk);
      total++;
      if (tx_vld !== 1'b1 || conn_state !== 3'd1 || drop_cnt !== 16'd1) begin
         bad++;
         $display("FAIL mid_setup: got vld=%b state=%0d drop=%0d want 1 1 1", tx_vld, conn_state, drop_cnt);
      end
      #2;
      resetn = 1'b0;
      #1;
      outs = {rd_check, tx_vld, tx_type, tx_seq, tx_ack, tx_tsval, tx_tsecr,
              conn_state, conn_up, conn_fail, drop_cnt};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL async_reset: got %h want all zero", outs);
      end
      @(negedge clk);
      resetn = 1'b1;
      tx_rdy = 1'b1;
      @(negedge clk);
      total++;
      if (tx_vld !== 1'b0 || conn_state !== 3'd0) begin
         bad++;
         $display("FAIL reset_lost_desc: got vld=%b state=%0d want 0 0", tx_vld, conn_state);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_open();
      test_peer_fin();
      test_backpressure();
      test_retry_fail();
      test_random_estab();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
